// File: rtl/lora_gps_sender.sv
// LoRa GPS frame sender: streams header, RAM payload and XOR checksum
// to a UART transmitter over a valid/ready byte handshake.
module lora_gps_sender #(
    parameter int          ADDR_WIDTH = 6,
    parameter int          DATA_WIDTH = 8,
    parameter int          FRAME_LEN  = 39,
    parameter logic [7:0]  HDR_BYTE   = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        FETCH,
        LATCH,
        SEND,
        CSUM,
        DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(FRAME_LEN - 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [7:0]            csum_q, csum_d;
    logic [7:0]            data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  xfer;

    assign xfer = valid_q & tx_ready;

    // Next-state and registered-output decode.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        data_d  = data_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (start) begin
                    state_d = HDR;
                    idx_d   = '0;
                    csum_d  = '0;
                    data_d  = HDR_BYTE;
                    valid_d = 1'b1;
                end
            end
            HDR: begin
                if (xfer) begin
                    state_d = FETCH;
                    valid_d = 1'b0;
                end
            end
            FETCH: begin
                state_d = LATCH;
            end
            LATCH: begin
                state_d = SEND;
                data_d  = ram_dout[7:0];
                csum_d  = csum_q ^ ram_dout[7:0];
                valid_d = 1'b1;
            end
            SEND: begin
                if (xfer) begin
                    if (idx_q == LAST_IDX) begin
                        // Checksum follows back-to-back; valid stays high.
                        state_d = CSUM;
                        data_d  = csum_q;
                        valid_d = 1'b1;
                    end else begin
                        state_d = FETCH;
                        idx_d   = idx_q + 1'b1;
                        valid_d = 1'b0;
                    end
                end
            end
            CSUM: begin
                if (xfer) begin
                    state_d = DONE;
                    valid_d = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            csum_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ram_addr = idx_q;
    assign tx_data  = data_q;
    assign tx_valid = valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_lora_gps_sender.sv
// Scoreboard bench for lora_gps_sender: default frame instance plus a
// FRAME_LEN=1 instance, each with a registered-address RAM model.
module tb_lora_gps_sender;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, start1;
    logic [5:0] ram_addr, ram_addr1;
    logic [7:0] ram_dout, ram_dout1;
    logic [7:0] tx_data, tx_data1;
    logic       tx_valid, tx_valid1;
    logic       tx_ready;
    logic       busy, busy1, done, done1;

    logic [7:0] mem  [0:63];
    logic [7:0] mem1 [0:63];

    int checks   = 0;
    int failures = 0;

    logic [7:0] q[$];
    logic [7:0] q1[$];
    int exp_lat = 0, exp_lat1 = 5;
    int exp_done = 0, done_cnt = 0;
    int exp_done1 = 0, done_cnt1 = 0;
    bit toggle = 0;

    lora_gps_sender dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .ram_addr(ram_addr), .ram_dout(ram_dout),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done)
    );

    lora_gps_sender #(.FRAME_LEN(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .ram_addr(ram_addr1), .ram_dout(ram_dout1),
        .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(1'b1),
        .busy(busy1), .done(done1)
    );

    always @(posedge clk) begin
        ram_dout  <= mem[ram_addr];
        ram_dout1 <= mem1[ram_addr1];
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Monitor for the default instance.
    int cyc = 0, t0 = 0;
    bit seen_first = 0, pv = 0, pr = 0;
    logic [7:0] pd = 0, e;
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            seen_first = 0;
            pv = 0;
        end else begin
            if (tx_valid && !seen_first) begin
                t0 = cyc;
                seen_first = 1;
            end
            if (pv && !pr) begin
                chk("stall_valid", {31'd0, tx_valid}, 32'd1);
                chk("stall_data", {24'd0, tx_data}, {24'd0, pd});
            end
            if (tx_valid && tx_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_byte", {24'd0, tx_data}, 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    chk("tx_byte", {24'd0, tx_data}, {24'd0, e});
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_q_empty", q.size(), 0);
                if (exp_lat > 0) chk("done_latency", cyc - t0, exp_lat);
                seen_first = 0;
            end
            pv = tx_valid;
            pr = tx_ready;
            pd = tx_data;
        end
    end

    // Monitor for the FRAME_LEN=1 instance.
    int t01 = 0;
    bit seen1 = 0;
    logic [7:0] e1;
    always @(negedge clk) begin
        if (!rst_n) begin
            seen1 = 0;
        end else begin
            if (tx_valid1 && !seen1) begin
                t01 = cyc;
                seen1 = 1;
            end
            if (tx_valid1) begin
                if (q1.size() == 0) begin
                    chk("unexpected_byte1", {24'd0, tx_data1}, 32'hFFFF_FFFF);
                end else begin
                    e1 = q1.pop_front();
                    chk("tx_byte1", {24'd0, tx_data1}, {24'd0, e1});
                end
            end
            if (done1) begin
                done_cnt1++;
                chk("done1_q_empty", q1.size(), 0);
                chk("done1_latency", cyc - t01, exp_lat1);
                seen1 = 0;
            end
        end
    end

    initial begin
        int rc = 0;
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rc++;
            tx_ready = toggle ? (rc % 3 == 0) : 1'b1;
        end
    end

    task automatic push_frame(input logic [7:0] pat, input bit inc);
        logic [7:0] cs;
        cs = 8'h00;
        q.push_back(8'hA5);
        for (int i = 0; i < 39; i++) begin
            logic [7:0] b;
            b = inc ? 8'(i + 1) : pat;
            q.push_back(b);
            cs = cs ^ b;
        end
        q.push_back(cs);
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic idle_check(input string name);
        @(posedge clk);
        #1;
        chk(name, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        start1 = 1'b0;
        for (int i = 0; i < 64; i++) begin
            mem[i]  = 8'(i + 1);
            mem1[i] = 8'h00;
        end
        mem1[0] = 8'h3C;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_valid", {31'd0, tx_valid}, 0);
        chk("rst_tx_data", {24'd0, tx_data}, 0);
        chk("rst_ram_addr", {26'd0, ram_addr}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        rst_n = 1'b1;

        // Incrementing payload, ready always high.
        exp_lat = 119;
        push_frame(8'h00, 1);
        q[40] = 8'h00;
        exp_done++;
        pulse_start();
        wait_done();
        idle_check("busy_after_inc");

        // Constant 0x55 payload.
        for (int i = 0; i < 64; i++) mem[i] = 8'h55;
        q.push_back(8'hA5);
        for (int i = 0; i < 39; i++) q.push_back(8'h55);
        q.push_back(8'h55);
        exp_done++;
        pulse_start();
        wait_done();
        idle_check("busy_after_55");

        // Ready asserted one cycle in three.
        for (int i = 0; i < 64; i++) mem[i] = 8'(i + 1);
        exp_lat = 0;
        toggle = 1;
        push_frame(8'h00, 1);
        exp_done++;
        pulse_start();
        wait_done();
        toggle = 0;
        idle_check("busy_after_toggle");

        // Extra start pulses mid-payload and during DONE.
        exp_lat = 119;
        push_frame(8'h00, 1);
        exp_done++;
        pulse_start();
        repeat (30) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("no_requeue_busy", {31'd0, busy}, 0);

        // Reset around payload byte 20, then a fresh frame.
        push_frame(8'h00, 1);
        pulse_start();
        repeat (60) @(posedge clk);
        #1 rst_n = 1'b0;
        q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("abort_tx_valid", {31'd0, tx_valid}, 0);
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_done", {31'd0, done}, 0);
        push_frame(8'h00, 1);
        exp_done++;
        pulse_start();
        wait_done();
        idle_check("busy_after_abort");

        // Single-byte frame instance.
        q1.push_back(8'hA5);
        q1.push_back(8'h3C);
        q1.push_back(8'h3C);
        exp_done1++;
        @(posedge clk);
        #1 start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        n = 0;
        while (!done1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!done1) chk("done1_timeout", 0, 1);
        repeat (5) @(posedge clk);
        #1;

        chk("done_count", done_cnt, exp_done);
        chk("q_left", q.size(), 0);
        chk("done1_count", done_cnt1, exp_done1);
        chk("q1_left", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lora_gps_sender.md
LORA_GPS_SENDER -- requirements
Module: lora_gps_sender

Interface
REQ-001 The block SHALL run on one clock; reset SHALL be synchronous and active-low.
REQ-002 Parameter ADDR_WIDTH, default 6, SHALL set the buffer RAM read-address width.
REQ-003 Parameter DATA_WIDTH, default 8, SHALL set the byte width; only 8 is supported.
REQ-004 Parameter FRAME_LEN, default 39, SHALL set the payload bytes per frame, legal range 1..2**ADDR_WIDTH.
REQ-005 Parameter HDR_BYTE, default 8'hA5, SHALL be the frame header byte.
REQ-006 Port clk, input, 1, SHALL be the system clock; all state changes on its rising edge.
REQ-007 Port rst_n, input, 1, SHALL be the synchronous active-low reset.
REQ-008 Port start, input, 1, SHALL request transmission of one frame.
REQ-009 Port ram_addr, output, ADDR_WIDTH, SHALL drive the buffer RAM read port B address.
REQ-010 Port ram_dout, input, DATA_WIDTH, SHALL carry RAM port B data, valid one cycle after ram_addr is presented (registered-address read).
REQ-011 Port tx_data, output, 8, SHALL carry the byte offered to the LoRa UART transmitter.
REQ-012 Port tx_valid, output, 1, SHALL flag tx_data as valid.
REQ-013 Port tx_ready, input, 1, SHALL indicate the UART transmitter accepts a byte.
REQ-014 Port busy, output, 1, SHALL be high while a frame is in progress (any state except IDLE).
REQ-015 Port done, output, 1, SHALL pulse high for one cycle when a frame completes.

Function
REQ-016 Frame SHALL be: HDR_BYTE, then RAM bytes at addresses 0..FRAME_LEN-1 in order, then checksum; FRAME_LEN+2 bytes total.
REQ-017 Checksum SHALL be the 8-bit XOR of all payload bytes only (header excluded), cleared to 0 at frame start.
REQ-018 A transfer SHALL occur on a rising edge where tx_valid and tx_ready are both high.
REQ-019 Once tx_valid rises, tx_valid and tx_data SHALL stay constant until the transfer edge; tx_ready low stalls indefinitely without data loss.
REQ-020 All outputs SHALL be registered; ram_addr SHALL equal the internal byte index register.
REQ-021 FSM states SHALL be IDLE, HDR, FETCH, LATCH, SEND, CSUM, DONE.
REQ-022 IDLE: start sampled high -> HDR, index=0, checksum=0; start low -> stay.
REQ-023 HDR: tx_data=HDR_BYTE, tx_valid=1; on transfer -> FETCH, tx_valid=0.
REQ-024 FETCH: one cycle, ram_addr=index presented -> LATCH.
REQ-025 LATCH: one cycle; at its end tx_data<=ram_dout, checksum<=checksum^ram_dout, tx_valid<=1 -> SEND.
REQ-026 SEND: on transfer, if index==FRAME_LEN-1 -> CSUM, else index+1 -> FETCH; tx_valid=0 on leaving.
REQ-027 CSUM: tx_data=checksum, tx_valid=1; on transfer -> DONE.
REQ-028 DONE: done=1 for exactly this cycle, tx_valid=0 -> IDLE unconditionally.
REQ-029 start while busy (including the DONE cycle) SHALL be ignored; no queuing.
REQ-030 Index SHALL never exceed FRAME_LEN-1; no address wrap occurs within a frame.
REQ-031 With tx_ready held high, done SHALL rise exactly 3*FRAME_LEN+2 cycles after tx_valid first rises (119 for default).

Reset
REQ-032 rst_n low at a rising edge SHALL force IDLE, tx_valid=0, tx_data=0, ram_addr=0, busy=0, done=0, checksum=0, from any state.
REQ-033 Reset mid-frame SHALL abort the frame with no done pulse; next start begins a fresh frame from the header.

Verification
REQ-034 RAM[i]=i+1 for i=0..38, tx_ready=1, pulse start -> bytes A5,01,02..27,00; done 119 cycles after first tx_valid.
REQ-035 RAM all 8'h55, tx_ready=1 -> 39 payload bytes 55, checksum 55, one done pulse, busy low afterward.
REQ-036 RAM[i]=i+1, tx_ready toggling 1-of-3 cycles -> identical byte sequence, tx_data stable while tx_valid high and tx_ready low.
REQ-037 start pulsed again at payload byte 10 and during DONE -> exactly one frame emitted, no second header.
REQ-038 rst_n low for one cycle during payload byte 20 -> tx_valid=0, busy=0, no done; next start yields full correct frame from A5.
REQ-039 FRAME_LEN=1, RAM[0]=8'h3C -> bytes A5,3C,3C; done 5 cycles after first tx_valid.
